mpres_meter: RTL and testbench
==============================

# mpres_meter

Four-channel period meter: the receiving end of the multiple-prescaler outputs D1..D4. It synchronizes each prescaler output to `clk_in`, detects rising edges, and measures the period in `clk_in` cycles. One selected channel's period, valid and overflow flags are presented on registered outputs. It sits beside the prescaler bank as a self-check and measurement block, in simulation or on the board.

## Interface
- `W`, default 8: period counter width in bits. Legal range is 2..16.
- `clk_in`  input  1  system clock. All logic is on the rising edge.
- `rstn`  input  1  reset, asynchronous, active-low.
- `D1`, `D2`, `D3`, `D4`  input  1 each  signals under measurement, treated as asynchronous.
- `sel`  input  2  channel select: 0 selects D1 through 3 selects D4.
- `period`  output  W  last measured period of the selected channel, in `clk_in` cycles.
- `valid`  output  1  selected channel holds a valid measurement.
- `ovf`  output  1  selected channel's counter saturated since its last valid measurement.
- `edge`  output  4  one-cycle pulse per channel on each detected rising edge; bit 0 is D1.

## Operation
- Per channel synchronizer chain `s1` → `s2` → `s3`.
- Edge detect: `rise = s2 & ~s3`.
- Per channel counter `cnt` (W bits):
  - Cleared to 0 on `rise`.
  - Otherwise increments, saturating at 2^W−1.
- Per channel state machine: IDLE → ARMED → LOCKED.
  - IDLE: on `rise`, go to ARMED and set `cnt` to 0. No period is recorded.
  - ARMED, on `rise`: record `per = cnt+1`, go to LOCKED.
  - LOCKED, on `rise`: record `per = cnt+1` on every rising edge.
  - Exact period: two edges P cycles apart give `per = P`.
- Saturation:
  - When `cnt == 2^W−1` with no `rise`, set the channel's `ovf`.
  - A `rise` while `cnt` is saturated records `per = 2^W−1` and keeps `ovf` set.
  - The next non-saturated measurement clears `ovf`.
- Channel valid flag = (state == LOCKED).
- Output stage registers on every clock: `period <= per[sel]`, `valid <= lock[sel]`, `ovf <= ovf[sel]`.
- `edge[n]` = `rise` of channel n, registered.
- Reset values:
  - All outputs 0.
  - All channels in IDLE; `cnt`, `per` and channel `ovf` all 0.
  - Synchronizer flops 0.
- Reset mid-measurement: everything returns to reset values immediately, asynchronously. The first edge after reset only arms the channel.
- An input that is already high when `rstn` deasserts counts as a rising edge two cycles later, because `s1..s3` start at 0.

## Timing
- Timestamps: Dn rises before clock edge t.
  - `s1` = 1 at t, `s2` at t+1, `s3` at t+2.
  - `rise` is high during cycle t+1..t+2.
- Channel `per`, state and `cnt` update at edge t+2.
- `period`, `valid` and `edge[n]` are visible after edge t+3, when `sel` = n: 3-cycle input-to-output latency.
- `sel` change: the outputs reflect the new channel after one clock edge. No handshake; `sel` is sampled every cycle.
- Measurable period range: 2 to 2^W−1 cycles. Input pulses shorter than one `clk_in` period may be missed.
- Channels are independent; simultaneous edges on all four are each handled in the same cycle.

## Configuration
- Macro: `MPRES_METER_TIMEOUT_EN`.
- Defined:
  - A LOCKED or ARMED channel whose `cnt` reaches 2^W−1 with no `rise` returns to IDLE, so `valid` drops.
  - `ovf` sets and `per` is held.
  - The next edge re-arms the channel; a second edge is needed before it is valid again.
- Undefined: no timeout. The channel stays LOCKED with its last `per`; only `ovf` sets on saturation.

## Structure
- Package `mpres_meter_pkg`: channel-state enum (IDLE, ARMED, LOCKED) and constant `NCH = 4`.
- Sub-module `mpres_period_chan`, instantiated 4 times. It contains the synchronizer, edge detector, counter, state machine, `per` and `ovf`, parameterized by `W`.
- Top level: the 4 instances plus the registered `sel` mux and the `edge` register.

## Test plan
- Prescaler bank with N1=1, N2=2, N3=3, N4=4 driving D1..D4, `W=8`, sweep `sel` 0..3 after 100 cycles → `period` = 2, 4, 8, 16, `valid` = 1, `ovf` = 0.
- Reset, then a single isolated pulse on D1 → `edge[0]` pulses once 3 cycles later; `valid` stays 0 (channel ARMED only).
- `W=4`, D2 with period 32 (N=5) → `period` = 15, `ovf` = 1. Then switch D2 to period 8 → `period` = 8, `ovf` = 0 after two edges.
- With `MPRES_METER_TIMEOUT_EN`, D3 locked at period 8, then held low → `valid` falls 15 cycles after the last edge (`W=4`). Without the macro, `valid` stays 1 and `period` = 8.
- `rstn` asserted mid-run with all channels locked → all outputs 0 at once. After release, `valid` returns only after the second edge on each channel.
- D1 held high through reset release → one `edge[0]` pulse 3 cycles after release, and no `valid` until the next rising edge.

Source files
------------

// File: rtl/mpres_meter_pkg.sv
// mpres_meter_pkg: shared channel-state encoding and channel count for the period meter.
package mpres_meter_pkg;
    localparam int NCH = 4;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_LOCKED
    } chan_state_e;
endpackage

// File: rtl/mpres_period_chan.sv
// mpres_period_chan: one measurement channel.
// It synchronises an asynchronous input, detects its rising edges, counts clk_in
// cycles between them and records the period.
// Ports: clk_in/rstn   clock and async active-low reset
//        d             asynchronous signal under measurement
//        rise_o        registered rising-edge pulse
//        per           last recorded period, saturating at 2^W-1
//        lock          channel holds a valid measurement
//        ovf           counter saturated since the last valid measurement
// Macro MPRES_METER_TIMEOUT_EN: a saturated ARMED/LOCKED channel drops back to IDLE.
module mpres_period_chan
    import mpres_meter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rstn,
    input  logic         d,
    output logic         rise_o,
    output logic [W-1:0] per,
    output logic         lock,
    output logic         ovf
);
    localparam logic [W-1:0] MAX = '1;
    logic [2:0]   sync_q, sync_d;
    logic [W-1:0] cnt_q, cnt_d, per_q, per_d;
    logic         ovf_q, ovf_d, rise_q, rise_d;
    logic         rise, sat;
    chan_state_e  state_q, state_d;

    always_comb begin
        sync_d  = {sync_q[1:0], d};
        rise    = sync_q[1] & ~sync_q[2];
        sat     = cnt_q == MAX;
        rise_d  = rise;
        cnt_d   = rise ? '0 : (sat ? cnt_q : cnt_q + 1'b1);
        state_d = state_q;
        per_d   = per_q;
        ovf_d   = ovf_q;
        if (rise) begin
            state_d = (state_q == ST_IDLE) ? ST_ARMED : ST_LOCKED;
            // The first edge out of IDLE only starts the count.
            if (state_q != ST_IDLE) begin
                per_d = sat ? MAX : cnt_q + 1'b1;
                ovf_d = sat;
            end
        end else if (sat) begin
            ovf_d = 1'b1;
`ifdef MPRES_METER_TIMEOUT_EN
            state_d = ST_IDLE;
`endif
        end
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            per_q   <= '0;
            ovf_q   <= 1'b0;
            rise_q  <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            ovf_q   <= ovf_d;
            rise_q  <= rise_d;
            state_q <= state_d;
        end
    end

    assign rise_o = rise_q;
    assign per    = per_q;
    assign lock   = state_q == ST_LOCKED;
    assign ovf    = ovf_q;
endmodule

// File: rtl/mpres_meter.sv
// mpres_meter: four-channel period meter for the prescaler outputs D1..D4.
// Ports: clk_in/rstn   clock and async active-low reset
//        D1..D4        asynchronous signals under measurement
//        sel           channel select (0 = D1 .. 3 = D4)
//        period        registered period of the selected channel, in clk_in cycles
//        valid         selected channel is locked
//        ovf           selected channel's counter saturated
//        edge_o        one-cycle rising-edge pulse per channel, bit 0 = D1
// Macro MPRES_METER_TIMEOUT_EN: saturated channels time out back to IDLE.
module mpres_meter
    import mpres_meter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rstn,
    input  logic         D1,
    input  logic         D2,
    input  logic         D3,
    input  logic         D4,
    input  logic [1:0]   sel,
    output logic [W-1:0] period,
    output logic         valid,
    output logic         ovf,
    output logic [3:0]   edge_o
);
    logic [NCH-1:0] d_in, rise, lock, ovf_ch;
    logic [W-1:0]   per [NCH];
    logic [W-1:0]   period_q, period_d;
    logic           valid_q, valid_d, ovf_q, ovf_d;
    logic [3:0]     edge_q, edge_d;

    assign d_in = {D4, D3, D2, D1};

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        mpres_period_chan #(.W(W)) u_chan (
            .clk_in (clk_in),
            .rstn   (rstn),
            .d      (d_in[g]),
            .rise_o (rise[g]),
            .per    (per[g]),
            .lock   (lock[g]),
            .ovf    (ovf_ch[g])
        );
    end

    always_comb begin
        period_d = per[sel];
        valid_d  = lock[sel];
        ovf_d    = ovf_ch[sel];
        edge_d   = rise;
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            edge_q   <= '0;
        end else begin
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            edge_q   <= edge_d;
        end
    end

    assign period = period_q;
    assign valid  = valid_q;
    assign ovf    = ovf_q;
    assign edge_o = edge_q;
endmodule

// File: tb/tb_mpres_meter.sv
// tb_mpres_meter: directed checks of the period meter at W=8 and W=4.
module tb_mpres_meter;
    logic       clk_in = 1'b0;
    logic       rstn = 1'b0;
    logic       a1 = 0, a2 = 0, a3 = 0, a4 = 0;
    logic       b1 = 0, b2 = 0, b3 = 0, b4 = 0;
    logic [1:0] sel8 = 0, sel4 = 0;
    logic [7:0] period8;
    logic [3:0] period4;
    logic       valid8, ovf8, valid4, ovf4;
    logic [3:0] edge8, edge4;
    logic [7:0] pc = 0;
    logic       pres_on = 0, gen_on = 0;
    int         b_per = 8, b_ph = 0;
    logic [3:0] bmask = 0;
    logic       exp_v;
    int         checks = 0, errors = 0;

    always #5 clk_in = ~clk_in;

    mpres_meter #(.W(8)) u8 (
        .clk_in(clk_in), .rstn(rstn), .D1(a1), .D2(a2), .D3(a3), .D4(a4), .sel(sel8),
        .period(period8), .valid(valid8), .ovf(ovf8), .edge_o(edge8)
    );

    mpres_meter #(.W(4)) u4 (
        .clk_in(clk_in), .rstn(rstn), .D1(b1), .D2(b2), .D3(b3), .D4(b4), .sel(sel4),
        .period(period4), .valid(valid4), .ovf(ovf4), .edge_o(edge4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk_in);
            pc = pc + 1'b1;
            if (pres_on) {a4, a3, a2, a1} = pc[3:0];
            if (gen_on) begin
                b_ph = (b_ph + 1) % b_per;
                {b4, b3, b2, b1} = (b_ph < b_per / 2) ? bmask : 4'b0;
            end
        end
    endtask

    initial begin
        cyc(3);
        chk("rst_period8", period8, 0);
        chk("rst_valid8", valid8, 0);
        chk("rst_ovf8", ovf8, 0);
        chk("rst_edge8", edge8, 0);
        chk("rst_period4", period4, 0);
        chk("rst_valid4", valid4, 0);
        chk("rst_edge4", edge4, 0);
        // prescaler bank: D1..D4 periods 2,4,8,16
        rstn = 1'b1;
        pres_on = 1'b1;
        cyc(100);
        for (int s = 0; s < 4; s++) begin
            sel8 = 2'(s);
            cyc(1);
            chk($sformatf("pres_period_sel%0d", s), period8, 32'd2 << s);
            chk($sformatf("pres_valid_sel%0d", s), valid8, 1);
            chk($sformatf("pres_ovf_sel%0d", s), ovf8, 0);
        end
        // reset while locked clears outputs at once
        rstn = 1'b0;
        #1;
        chk("midrst_period", period8, 0);
        chk("midrst_valid", valid8, 0);
        chk("midrst_edge", edge8, 0);
        pres_on = 1'b0;
        {a4, a3, a2, a1} = 4'b0;
        sel8 = 0;
        cyc(3);
        rstn = 1'b1;
        cyc(3);
        // single isolated pulse only arms D1
        a1 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            chk($sformatf("pulse_edge_k%0d", k), edge8, (k == 4) ? 4'b0001 : 4'b0000);
            chk($sformatf("pulse_valid_k%0d", k), valid8, 0);
            if (k == 1) a1 = 1'b0;
        end
        cyc(4);
        // second pulse 10 cycles after the first locks the channel
        a1 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            if (k == 1) a1 = 1'b0;
            if (k >= 3) chk($sformatf("second_valid_k%0d", k), valid8, (k == 4) ? 1 : 0);
        end
        chk("second_period", period8, 10);
        chk("second_ovf", ovf8, 0);
        // D1 high through reset release: one arming edge, no valid
        rstn = 1'b0;
        a1 = 1'b1;
        cyc(2);
        rstn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            chk($sformatf("held_edge_k%0d", k), edge8, (k == 4) ? 4'b0001 : 4'b0000);
            chk($sformatf("held_valid_k%0d", k), valid8, 0);
        end
        a1 = 1'b0;
        cyc(3);
        a1 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            if (k >= 3) chk($sformatf("held_lock_k%0d", k), valid8, (k == 4) ? 1 : 0);
        end
        chk("held_period", period8, 8);
        // W=4 saturation: period 32 reads 15 with ovf
        sel4 = 2'd1;
        bmask = 4'b0010;
        b_per = 32;
        b_ph = 0;
        gen_on = 1'b1;
        cyc(150);
        chk("sat_period", period4, 15);
        chk("sat_ovf", ovf4, 1);
        chk("sat_valid", valid4, 1);
        b_per = 8;
        b_ph = 0;
        cyc(40);
        chk("unsat_period", period4, 8);
        chk("unsat_ovf", ovf4, 0);
        chk("unsat_valid", valid4, 1);
        gen_on = 1'b0;
        {b4, b3, b2, b1} = 4'b0;
        // D3 locked at period 8, then held low
        sel4 = 2'd2;
        repeat (6) begin
            b3 = 1'b1;
            cyc(4);
            b3 = 1'b0;
            cyc(4);
        end
        chk("d3_period", period4, 8);
        chk("d3_valid", valid4, 1);
        chk("d3_ovf", ovf4, 0);
        cyc(11);
        chk("d3_pre_ovf", ovf4, 0);
        chk("d3_pre_valid", valid4, 1);
        cyc(1);
`ifdef MPRES_METER_TIMEOUT_EN
        exp_v = 1'b0;
`else
        exp_v = 1'b1;
`endif
        chk("d3_ovf_set", ovf4, 1);
        chk("d3_timeout_valid", valid4, 32'(exp_v));
        chk("d3_held_period", period4, 8);
        cyc(10);
        chk("d3_late_valid", valid4, 32'(exp_v));
        chk("d3_late_period", period4, 8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
